qdr_rd_scheduler: RTL and testbench

- Read-side scheduler for the QDR pcap replay memory. It shares the single QDR read port between NUM_QUEUES replay queues.
- Tracks a read pointer and a replay count per queue, and arbitrates round-robin among eligible queues.
- Issues one burst read per grant.
- Tags each read with its QID, delayed by the memory read latency, so the downstream splitter routes returned data to the right per-queue FIFO.

---
 rtl/qdr_rd_scheduler_pkg.sv | 21 ++
 rtl/qdr_rr_arbiter.sv | 43 ++++
 rtl/qdr_rd_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_qdr_rd_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr_rd_scheduler_pkg.sv
// Shared types and constants for the QDR read-side scheduler and its round-robin arbiter.
package qdr_rd_scheduler_pkg;

  typedef enum logic [1:0] {
    Q_IDLE = 2'd0,
    Q_RUN  = 2'd1,
    Q_DONE = 2'd2
  } q_state_e;

  localparam int DEF_MEM_ADDR_WIDTH = 19;
  localparam int DEF_MEM_RD_LATENCY = 8;

  // Ceiling log2, never below 1 so a single-queue build still has a usable QID bit.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/qdr_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer, pointer moves past the winner.
module qdr_rr_arbiter
  import qdr_rd_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int NB = log2c(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt_oh,
  output logic [NB-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [NB-1:0] ptr_q, ptr_d;
  logic [NB-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = NB'((int'(ptr_q) + k) % N);
      if (!gnt_vld && req[cand]) begin
        gnt_vld      = 1'b1;
        gnt_idx      = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + NB'(1);
    if (clr) ptr_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/qdr_rd_scheduler.sv
// QDR read scheduler: per-queue replay FSMs sharing one read port, with a QID tag pipe matched to read latency.
// Build option QDR_RD_STATS_EN adds per-queue issued-burst counters on q_rd_count.
//
// state  | meaning
// IDLE   | queue parked, waiting for q_start with q_enable
// RUN    | queue requesting reads; rd_ptr walks the stored data, replaying as needed
// DONE   | all passes issued (or region empty); held until q_enable drops
module qdr_rd_scheduler
  import qdr_rd_scheduler_pkg::*;
#(
  parameter int NUM_QUEUES       = 4,
  parameter int NUM_QUEUES_BITS  = log2c(NUM_QUEUES),
  parameter int MEM_ADDR_WIDTH   = DEF_MEM_ADDR_WIDTH,
  parameter int REPLAY_CNT_WIDTH = 16,
  parameter int MEM_RD_LATENCY   = DEF_MEM_RD_LATENCY
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   sw_rst,
  input  logic                                   cal_done,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]   q_addr_low,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]   q_addr_high,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]   q_wr_ptr,
  input  logic [NUM_QUEUES-1:0]                  q_enable,
  input  logic [NUM_QUEUES-1:0]                  q_start,
  input  logic [NUM_QUEUES*REPLAY_CNT_WIDTH-1:0] q_replay_cnt,
  input  logic [NUM_QUEUES-1:0]                  q_fifo_afull,
  input  logic                                   mem_rd_full,
  output logic                                   mem_r_n,
  output logic [MEM_ADDR_WIDTH-1:0]              mem_ad_rd,
  output logic                                   rd_tag_valid,
  output logic [NUM_QUEUES_BITS-1:0]             rd_tag_qid,
  output logic [NUM_QUEUES-1:0]                  q_active,
  output logic [NUM_QUEUES-1:0]                  q_done,
  output logic [NUM_QUEUES*32-1:0]               q_rd_count
);

  localparam int NQ  = NUM_QUEUES;
  localparam int NB  = NUM_QUEUES_BITS;
  localparam int AW  = MEM_ADDR_WIDTH;
  localparam int RW  = REPLAY_CNT_WIDTH;
  localparam int LAT = MEM_RD_LATENCY;

  q_state_e      state_q [NQ];
  q_state_e      state_d [NQ];
  logic [AW-1:0] rd_ptr_q[NQ];
  logic [AW-1:0] rd_ptr_d[NQ];
  logic [RW-1:0] rem_q   [NQ];
  logic [RW-1:0] rem_d   [NQ];

  logic [NQ-1:0] req, gnt_oh;
  logic [NB-1:0] gnt_idx;
  logic          gnt_vld;

  logic          mem_r_n_q, mem_r_n_d;
  logic [AW-1:0] mem_ad_q, mem_ad_d;
  logic [NB-1:0] iss_qid_q, iss_qid_d;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [NB-1:0] tag_qid_q[LAT];
  logic [NB-1:0] tag_qid_d[LAT];

  always_comb begin
    req = '0;
    for (int i = 0; i < NQ; i++)
      req[i] = (state_q[i] == Q_RUN) && !q_fifo_afull[i] && cal_done && !mem_rd_full;
  end

  qdr_rr_arbiter #(.N(NQ), .NB(NB)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (sw_rst),
    .req     (req),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    logic [AW-1:0] lo, hi, wp, nxt;
    logic          end_hit;
    lo = '0; hi = '0; wp = '0; nxt = '0; end_hit = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      lo          = q_addr_low [i*AW +: AW];
      hi          = q_addr_high[i*AW +: AW];
      wp          = q_wr_ptr   [i*AW +: AW];
      // AW-bit wrap lets addr_high==0 stand for the top of memory.
      nxt         = rd_ptr_q[i] + AW'(1);
      end_hit     = (nxt == wp) || (nxt == hi);
      state_d[i]  = state_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      rem_d[i]    = rem_q[i];
      if (sw_rst || !q_enable[i]) begin
        state_d[i] = Q_IDLE;
      end else begin
        case (state_q[i])
          Q_IDLE: if (q_start[i]) begin
            rd_ptr_d[i] = lo;
            rem_d[i]    = q_replay_cnt[i*RW +: RW];
            state_d[i]  = (wp == lo) ? Q_DONE : Q_RUN;
          end
          Q_RUN: if (gnt_oh[i]) begin
            if (!end_hit) begin
              rd_ptr_d[i] = nxt;
            end else if (rem_q[i] == '0) begin
              state_d[i] = Q_DONE;
            end else begin
              rd_ptr_d[i] = lo;
              rem_d[i]    = rem_q[i] - RW'(1);
            end
          end
          Q_DONE: ;
          default: state_d[i] = Q_IDLE;
        endcase
      end
    end
  end

  // Tag pipe is fed from the strobe register, so its last stage lines up LAT cycles after the strobe.
  always_comb begin
    mem_r_n_d = ~gnt_vld;
    mem_ad_d  = gnt_vld ? rd_ptr_q[gnt_idx] : mem_ad_q;
    iss_qid_d = gnt_idx;
    tag_vld_d = '0;
    tag_vld_d[0] = ~mem_r_n_q;
    tag_qid_d[0] = iss_qid_q;
    for (int k = 1; k < LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_qid_d[k] = tag_qid_q[k-1];
    end
    if (sw_rst) begin
      mem_r_n_d = 1'b1;
      mem_ad_d  = '0;
      iss_qid_d = '0;
      tag_vld_d = '0;
      for (int k = 0; k < LAT; k++) tag_qid_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NQ; i++) begin
        state_q[i]  <= Q_IDLE;
        rd_ptr_q[i] <= '0;
        rem_q[i]    <= '0;
      end
      mem_r_n_q <= 1'b1;
      mem_ad_q  <= '0;
      iss_qid_q <= '0;
      tag_vld_q <= '0;
      for (int k = 0; k < LAT; k++) tag_qid_q[k] <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        state_q[i]  <= state_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        rem_q[i]    <= rem_d[i];
      end
      mem_r_n_q <= mem_r_n_d;
      mem_ad_q  <= mem_ad_d;
      iss_qid_q <= iss_qid_d;
      tag_vld_q <= tag_vld_d;
      for (int k = 0; k < LAT; k++) tag_qid_q[k] <= tag_qid_d[k];
    end
  end

  assign mem_r_n      = mem_r_n_q;
  assign mem_ad_rd    = mem_ad_q;
  assign rd_tag_valid = tag_vld_q[LAT-1];
  assign rd_tag_qid   = tag_qid_q[LAT-1];

  always_comb begin
    q_active = '0;
    q_done   = '0;
    for (int i = 0; i < NQ; i++) begin
      q_active[i] = (state_q[i] == Q_RUN);
      q_done[i]   = (state_q[i] == Q_DONE);
    end
  end

`ifdef QDR_RD_STATS_EN
  logic [31:0] cnt_q[NQ];
  logic [31:0] cnt_d[NQ];

  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!mem_r_n_q && iss_qid_q == NB'(i) && cnt_q[i] != 32'hFFFF_FFFF)
        cnt_d[i] = cnt_q[i] + 32'd1;
      if (q_start[i] || sw_rst) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NQ; i++) cnt_q[i] <= '0;
    else        for (int i = 0; i < NQ; i++) cnt_q[i] <= cnt_d[i];
  end

  always_comb begin
    q_rd_count = '0;
    for (int i = 0; i < NQ; i++) q_rd_count[i*32 +: 32] = cnt_q[i];
  end
`else
  assign q_rd_count = '0;
`endif

endmodule

// File: tb/tb_qdr_rd_scheduler.sv
// Bench for qdr_rd_scheduler: directed scenarios plus randomized replay runs against an address-list reference model.
module tb_qdr_rd_scheduler;
  import qdr_rd_scheduler_pkg::*;

  localparam int NQ  = 4;
  localparam int NB  = 2;
  localparam int AW  = 19;
  localparam int RW  = 16;
  localparam int LAT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sw_rst, cal_done, mem_rd_full;
  logic [NQ*AW-1:0] q_addr_low, q_addr_high, q_wr_ptr;
  logic [NQ-1:0]    q_enable, q_start, q_fifo_afull;
  logic [NQ*RW-1:0] q_replay_cnt;
  logic             mem_r_n, rd_tag_valid;
  logic [AW-1:0]    mem_ad_rd;
  logic [NB-1:0]    rd_tag_qid;
  logic [NQ-1:0]    q_active, q_done;
  logic [NQ*32-1:0] q_rd_count;

  logic [AW-1:0] cfg_lo[NQ];
  logic [AW-1:0] cfg_hi[NQ];
  logic [AW-1:0] cfg_wp[NQ];
  logic [RW-1:0] cfg_rc[NQ];

  always_comb begin
    q_addr_low = '0; q_addr_high = '0; q_wr_ptr = '0; q_replay_cnt = '0;
    for (int i = 0; i < NQ; i++) begin
      q_addr_low[i*AW +: AW]   = cfg_lo[i];
      q_addr_high[i*AW +: AW]  = cfg_hi[i];
      q_wr_ptr[i*AW +: AW]     = cfg_wp[i];
      q_replay_cnt[i*RW +: RW] = cfg_rc[i];
    end
  end

  qdr_rd_scheduler #(
    .NUM_QUEUES(NQ), .NUM_QUEUES_BITS(NB), .MEM_ADDR_WIDTH(AW),
    .REPLAY_CNT_WIDTH(RW), .MEM_RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .cal_done(cal_done),
    .q_addr_low(q_addr_low), .q_addr_high(q_addr_high), .q_wr_ptr(q_wr_ptr),
    .q_enable(q_enable), .q_start(q_start), .q_replay_cnt(q_replay_cnt),
    .q_fifo_afull(q_fifo_afull), .mem_rd_full(mem_rd_full),
    .mem_r_n(mem_r_n), .mem_ad_rd(mem_ad_rd), .rd_tag_valid(rd_tag_valid),
    .rd_tag_qid(rd_tag_qid), .q_active(q_active), .q_done(q_done),
    .q_rd_count(q_rd_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_tagv   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {logic v; logic [NB-1:0] q;} tag_t;
  typedef struct {int cyc; int q; logic [AW-1:0] addr;} strobe_t;

  tag_t    hist[LAT] = '{default: '0};
  strobe_t strobes[$];
  logic [AW-1:0] exp_q[$];

  function automatic int region_of(input logic [AW-1:0] a);
    for (int i = 0; i < NQ; i++)
      if (a >= cfg_lo[i] && (cfg_hi[i] == '0 || a < cfg_hi[i])) return i;
    return -1;
  endfunction

  // Expected tags: every strobe reappears as a tag exactly LAT cycles later; any reset discards them.
  always @(negedge clk) begin : mon
    tag_t e, cur;
    int r;
    cyc++;
    e = rst_n ? hist[LAT-1] : '0;
    check("tag_valid", {63'd0, rd_tag_valid}, {63'd0, e.v});
    if (e.v) check("tag_qid", {62'd0, rd_tag_qid}, {62'd0, e.q});
    if (rd_tag_valid) n_tagv++;
    for (int k = LAT - 1; k > 0; k--) hist[k] = hist[k-1];
    cur = '0;
    if (rst_n && !mem_r_n) begin
      r = region_of(mem_ad_rd);
      check("strobe_region", {63'd0, r >= 0}, 64'd1);
      cur.v = 1'b1;
      cur.q = r[NB-1:0];
      strobes.push_back('{cyc, r, mem_ad_rd});
    end
    hist[0] = cur;
    if (!rst_n || sw_rst) for (int k = 0; k < LAT; k++) hist[k] = '0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference read list: each pass walks low upward until the next address hits wr_ptr or addr_high.
  task automatic build_exp(input int i);
    logic [AW-1:0] a, nx;
    exp_q.delete();
    if (cfg_wp[i] == cfg_lo[i]) return;
    for (int p = 0; p <= int'(cfg_rc[i]); p++) begin
      a = cfg_lo[i];
      for (int g = 0; g < 4096; g++) begin
        exp_q.push_back(a);
        nx = a + 1'b1;
        if (nx == cfg_wp[i] || nx == cfg_hi[i]) break;
        a = nx;
      end
    end
  endtask

  task automatic compare_queue(input int i, input string t);
    logic [AW-1:0] got[$];
    build_exp(i);
    foreach (strobes[k]) if (strobes[k].q == i) got.push_back(strobes[k].addr);
    check($sformatf("%s_q%0d_count", t, i), 64'(got.size()), 64'(exp_q.size()));
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      check($sformatf("%s_q%0d_addr%0d", t, i, k), 64'(got[k]), 64'(exp_q[k]));
  endtask

  task automatic wait_done(input logic [NQ-1:0] m, input int bound, input string t);
    int n;
    n = 0;
    while ((q_done & m) != m && n < bound) begin step(1); n++; end
    check({t, "_done"}, 64'(q_done & m), 64'(m));
  endtask

  function automatic int nxt013(input int q);
    return (q == 0) ? 1 : (q == 1) ? 3 : 0;
  endfunction

  task automatic start_queues(input logic [NQ-1:0] m);
    q_enable = q_enable | m;
    q_start  = m;
    step(1);
    q_start  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s, cnt, snap;
    logic found;
    rst_n = 1'b0; sw_rst = 1'b0; cal_done = 1'b1; mem_rd_full = 1'b0;
    q_enable = '0; q_start = '0; q_fifo_afull = '0;
    for (int i = 0; i < NQ; i++) begin
      cfg_lo[i] = AW'(32'h100 * (i + 1));
      cfg_hi[i] = cfg_lo[i] + AW'(32'h80);
      cfg_wp[i] = cfg_hi[i];
      cfg_rc[i] = '0;
    end
    cfg_wp[0] = 19'h104;
    cfg_wp[1] = 19'h202; cfg_rc[1] = 16'd2;
    step(3);
    check("rst_mem_r_n", 64'(mem_r_n), 64'd1);
    check("rst_mem_ad", 64'(mem_ad_rd), 64'd0);
    check("rst_tag_valid", 64'(rd_tag_valid), 64'd0);
    check("rst_tag_qid", 64'(rd_tag_qid), 64'd0);
    check("rst_active", 64'(q_active), 64'd0);
    check("rst_done", 64'(q_done), 64'd0);
    check("rst_rd_count", 64'(q_rd_count[63:0]), 64'd0);
    rst_n = 1'b1;
    step(2);

    // Single queue, play once
    strobes.delete();
    start_queues(4'b0001);
    wait_done(4'b0001, 100, "t1");
    step(LAT + 2);
    compare_queue(0, "t1");
    for (int k = 1; k < strobes.size(); k++)
      check($sformatf("t1_contig%0d", k), 64'(strobes[k].cyc), 64'(strobes[k-1].cyc + 1));
    check("t1_active", 64'(q_active[0]), 64'd0);
`ifdef QDR_RD_STATS_EN
    check("t1_rd_count", 64'(q_rd_count[31:0]), 64'd4);
`else
    check("t1_rd_count", 64'(q_rd_count[31:0]), 64'd0);
`endif

    // Replay twice more
    strobes.delete();
    start_queues(4'b0010);
    wait_done(4'b0010, 100, "t2");
    step(LAT + 2);
    compare_queue(1, "t2");
    q_enable = '0;
    step(2);
    check("t2_idle_done", 64'(q_done), 64'd0);

    // Empty region
    cfg_wp[3] = cfg_lo[3];
    strobes.delete();
    start_queues(4'b1000);
    check("empty_done", 64'(q_done[3]), 64'd1);
    check("empty_active", 64'(q_active[3]), 64'd0);
    step(LAT + 2);
    check("empty_strobes", 64'(strobes.size()), 64'd0);
    q_enable = '0;

    // Fairness, afull skip, backpressure
    sw_rst = 1'b1; step(1); sw_rst = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      cfg_lo[i] = AW'(32'h1000 * (i + 1));
      cfg_hi[i] = cfg_lo[i] + AW'(32'h40);
      cfg_wp[i] = cfg_hi[i];
      cfg_rc[i] = '0;
    end
    strobes.delete();
    start_queues(4'b1111);
    step(12);
    check("rr_size", 64'(strobes.size() >= 9), 64'd1);
    for (int k = 0; k < 8 && k + 1 < strobes.size(); k++) begin
      check($sformatf("rr_qid%0d", k), 64'(strobes[k].q), 64'(k % 4));
      check($sformatf("rr_contig%0d", k), 64'(strobes[k+1].cyc), 64'(strobes[k].cyc + 1));
    end
    q_fifo_afull[2] = 1'b1;
    s = strobes.size();
    step(12);
    check("afull_size", 64'(strobes.size() >= s + 11), 64'd1);
    for (int k = s + 1; k < s + 10 && k + 1 < strobes.size(); k++) begin
      check($sformatf("afull_skip%0d", k - s), 64'(strobes[k].q != 2), 64'd1);
      check($sformatf("afull_order%0d", k - s), 64'(strobes[k+1].q), 64'(nxt013(strobes[k].q)));
      check($sformatf("afull_contig%0d", k - s), 64'(strobes[k+1].cyc), 64'(strobes[k].cyc + 1));
    end
    q_fifo_afull[2] = 1'b0;
    step(3);
    mem_rd_full = 1'b1;
    c0 = cyc;
    step(5);
    mem_rd_full = 1'b0;
    step(3);
    cnt = 0; found = 1'b0;
    foreach (strobes[k]) begin
      if (strobes[k].cyc >= c0 + 2 && strobes[k].cyc <= c0 + 6) cnt++;
      if (strobes[k].cyc == c0 + 7) found = 1'b1;
    end
    check("full_window", 64'(cnt), 64'd0);
    check("full_resume", 64'(found), 64'd1);
    wait_done(4'b1111, 600, "t3");
    step(LAT + 2);
    for (int i = 0; i < NQ; i++) compare_queue(i, "t3");

    // Enable dropped mid-run
    q_enable = '0;
    step(2);
    strobes.delete();
    start_queues(4'b0001);
    step(5);
    q_enable = '0;
    c0 = cyc;
    step(6);
    cnt = 0;
    foreach (strobes[k]) if (strobes[k].cyc >= c0 + 3) cnt++;
    check("drop_no_strobe", 64'(cnt), 64'd0);
    check("drop_active", 64'(q_active[0]), 64'd0);
    check("drop_done", 64'(q_done[0]), 64'd0);

    // Async reset with tags in flight
    start_queues(4'b0001);
    step(5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_r_n", 64'(mem_r_n), 64'd1);
    check("arst_mem_ad", 64'(mem_ad_rd), 64'd0);
    check("arst_tag_valid", 64'(rd_tag_valid), 64'd0);
    check("arst_tag_qid", 64'(rd_tag_qid), 64'd0);
    check("arst_active", 64'(q_active), 64'd0);
    snap = n_tagv;
    step(2);
    rst_n = 1'b1;
    step(LAT + 4);
    check("arst_no_tags", 64'(n_tagv), 64'(snap));
    check("arst_idle", 64'(q_active | q_done), 64'd0);

    // Randomized replays under random afull, full and calibration gaps
    for (int it = 0; it < 3; it++) begin
      q_enable = '0;
      step(2);
      for (int i = 0; i < NQ - 1; i++) begin
        cfg_lo[i] = AW'(32'h2000 * (i + 1) + $urandom_range(0, 15));
        cfg_wp[i] = cfg_lo[i] + AW'($urandom_range(2, 12));
        cfg_hi[i] = cfg_wp[i] + AW'($urandom_range(0, 3));
        cfg_rc[i] = RW'($urandom_range(0, 2));
      end
      cfg_lo[3] = 19'h7FFFC; cfg_hi[3] = '0; cfg_wp[3] = '0;
      cfg_rc[3] = RW'($urandom_range(0, 1));
      strobes.delete();
      start_queues(4'b1111);
      cnt = 0;
      while (q_done != 4'b1111 && cnt < 800) begin
        q_fifo_afull = NQ'($urandom);
        mem_rd_full  = ($urandom_range(0, 3) == 0);
        cal_done     = ($urandom_range(0, 7) != 0);
        step(1);
        cnt++;
      end
      q_fifo_afull = '0; mem_rd_full = 1'b0; cal_done = 1'b1;
      check($sformatf("rnd%0d_done", it), 64'(q_done), 64'hF);
      step(LAT + 2);
      for (int i = 0; i < NQ; i++) compare_queue(i, $sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
